// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: parity modes, tx state
// encoding and an elaboration-time clog2 helper.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_e;

    // Returns at least 1 so a counter sized from it is never zero-width.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return (result < 1) ? 1 : result;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of
// each bit. Held at zero while restart is high.
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic clk_8mhz,
    input  logic rst,
    input  logic restart,
    output logic bit_end
);

    localparam int CNT_W = clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk_8mhz or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (restart || bit_end)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    assign bit_end = (cnt == CNT_MAX);

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: valid/ready word input, configurable bit
// period, data width, parity and stop bits; frames run back-to-back.
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk_8mhz,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 tx_wire,
    output logic                 busy,
    output logic                 done
);

    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_clks
            $error("uart_tx_param: CLKS_PER_BIT must be >= 2");
        end
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
            $error("uart_tx_param: DATA_BITS must be 5..9");
        end
        if (PARITY != PARITY_NONE && PARITY != PARITY_ODD && PARITY != PARITY_EVEN) begin : g_bad_par
            $error("uart_tx_param: PARITY must be 0, 1 or 2");
        end
        if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
            $error("uart_tx_param: STOP_BITS must be 1 or 2");
        end
    endgenerate

    localparam int IDX_MAX = (DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS;
    localparam int IDX_W   = clog2(IDX_MAX);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);
    localparam logic             HAS_PAR   = (PARITY != PARITY_NONE);
    localparam logic             PAR_INV   = (PARITY == PARITY_ODD);

    tx_state_e            state, state_nxt;
    logic [IDX_W-1:0]     bit_idx, bit_idx_nxt;
    logic [DATA_BITS-1:0] shreg, shreg_nxt;
    logic                 par_bit, par_nxt;
    logic                 tx_nxt;
    logic                 bit_end;
    logic                 accept;

    uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
        .clk_8mhz (clk_8mhz),
        .rst      (rst),
        .restart  (state == ST_IDLE),
        .bit_end  (bit_end)
    );

    assign busy     = (state != ST_IDLE);
    assign done     = (state == ST_STOP) && (bit_idx == STOP_LAST) && bit_end;
    assign in_ready = (state == ST_IDLE) || done;
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_nxt   = state;
        bit_idx_nxt = bit_idx;
        shreg_nxt   = shreg;
        par_nxt     = par_bit;
        tx_nxt      = 1'b1;

        if (accept) begin
            shreg_nxt = in_data;
            par_nxt   = (^in_data) ^ PAR_INV;
        end

        case (state)
            ST_IDLE: begin
                if (accept)
                    state_nxt = ST_START;
            end
            ST_START: begin
                if (bit_end) begin
                    state_nxt   = ST_DATA;
                    bit_idx_nxt = '0;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    shreg_nxt = shreg >> 1;
                    if (bit_idx == DATA_LAST) begin
                        state_nxt   = HAS_PAR ? ST_PARITY : ST_STOP;
                        bit_idx_nxt = '0;
                    end else begin
                        bit_idx_nxt = bit_idx + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    state_nxt   = ST_STOP;
                    bit_idx_nxt = '0;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (bit_idx == STOP_LAST) begin
                        // Accept on the done cycle chains straight into a new start bit.
                        state_nxt   = accept ? ST_START : ST_IDLE;
                        bit_idx_nxt = '0;
                    end else begin
                        bit_idx_nxt = bit_idx + 1'b1;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        case (state_nxt)
            ST_START:  tx_nxt = 1'b0;
            ST_DATA:   tx_nxt = shreg_nxt[0];
            ST_PARITY: tx_nxt = par_nxt;
            default:   tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk_8mhz or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            bit_idx <= '0;
            shreg   <= '0;
            par_bit <= 1'b0;
            tx_wire <= 1'b1;
        end else begin
            state   <= state_nxt;
            bit_idx <= bit_idx_nxt;
            shreg   <= shreg_nxt;
            par_bit <= par_nxt;
            tx_wire <= tx_nxt;
        end
    end

endmodule
